// File: rtl/alu_adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package alu_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } alu_seq_state_e;

  // Width of the nibble index register; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/alu_adder_seq_if.sv
// Request/response handshake bundle for alu_adder_seq.
// rsp_overflow exists only when ALU_SEQ_OVERFLOW_EN is defined.
interface alu_adder_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_sub;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             rsp_overflow;
`endif

  // Issue side: drives requests, consumes responses.
  modport master (
`ifdef ALU_SEQ_OVERFLOW_EN
    input  rsp_overflow,
`endif
    output req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  // Sequencer side.
  modport slave (
`ifdef ALU_SEQ_OVERFLOW_EN
    output rsp_overflow,
`endif
    input  req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/alu_adder_seq_slice.sv
// alu_nibble_slice: combinational 4-bit adder shared by every step of the sequencer.
module alu_nibble_slice
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] result,
  output logic                carry_out
);

  // Plain ripple add with carry-in; the widened sum exposes the carry-out.
  always_comb begin
    {carry_out, result} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carry_in};
  end

endmodule

// File: rtl/alu_adder_seq.sv
// alu_adder_seq: WIDTH-bit add/subtract computed one nibble per cycle through a
// single alu_nibble_slice, least-significant nibble first.
// Optional signed-overflow flag: define ALU_SEQ_OVERFLOW_EN.
module alu_adder_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_adder_seq_if.slave        bus,
  output logic                  busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = idx_w(NIBBLES);

  alu_seq_state_e     state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_next;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic               last_step;

  logic [NIBBLE_W-1:0] sl_a;
  logic [NIBBLE_W-1:0] sl_b;
  logic [NIBBLE_W-1:0] sl_sum;
  logic                sl_cout;

  // Select the operand nibbles for the current step and merge the slice sum
  // into the partial result so the final step sees the complete word.
  always_comb begin
    sl_a      = op_a[idx*NIBBLE_W +: NIBBLE_W];
    sl_b      = op_b[idx*NIBBLE_W +: NIBBLE_W];
    last_step = (idx == IDX_W'(NIBBLES - 1));
    work_next = work;
    work_next[idx*NIBBLE_W +: NIBBLE_W] = sl_sum;
  end

  alu_nibble_slice u_slice (
    .a         (sl_a),
    .b         (sl_b),
    .carry_in  (carry_q),
    .result    (sl_sum),
    .carry_out (sl_cout)
  );

  // Sequencer FSM with registered handshake outputs and response flags.
  // Response fields are loaded from work_next on the last step so they change
  // only on entry to DONE and stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      busy           <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      work           <= '0;
      carry_q        <= 1'b0;
      idx            <= '0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      bus.rsp_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_a          <= bus.req_a;
            op_b          <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry_q       <= bus.req_sub ? 1'b1 : bus.req_cin;
            idx           <= '0;
            state         <= RUN;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        RUN: begin
          work    <= work_next;
          carry_q <= sl_cout;
          if (last_step) begin
            idx            <= '0;
            state          <= DONE;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= work_next;
            bus.rsp_carry  <= sl_cout;
            bus.rsp_zero   <= (work_next == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
            bus.rsp_overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                (work_next[WIDTH-1] != op_a[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
